// File: rtl/uart_tx_arbiter_pkg.sv
// Shared helpers for the UART transmit arbiter and its round-robin picker.
package uart_tx_arbiter_pkg;

  // Index width for an n-entry selector; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted request after last_idx,
// wrapping modulo N. Built as rotate, priority-encode, then add back.
module rr_pick
  import uart_tx_arbiter_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]              req,
  input  logic [idx_width(N)-1:0]   last_idx,
  output logic [idx_width(N)-1:0]   grant_idx,
  output logic                      any
);

  localparam int IW = idx_width(N);

  logic [2*N-1:0] req_dbl;
  logic [N-1:0]   req_rot;
  int             offset;
  int             pos;

  assign any = |req;

  // Rotate so that bit 0 is the port right after the previous winner.
  always_comb begin
    req_dbl = {req, req} >> (int'(last_idx) + 1);
    req_rot = req_dbl[N-1:0];
  end

  // Lowest set bit of the rotated vector is the winner's distance.
  always_comb begin
    offset = 0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_rot[i]) offset = i;
    end
  end

  // Undo the rotation to recover the absolute port index.
  always_comb begin
    pos = int'(last_idx) + 1 + offset;
    if (pos >= N) pos = pos - N;
    grant_idx = IW'(pos);
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-locked round-robin arbiter sharing one UART transmitter among
// N_PORTS byte producers, with an idle timeout that frees a stalled owner.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int N_PORTS  = 4,
  parameter int MAX_IDLE = 1024
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [N_PORTS*8-1:0]         req_data,
  input  logic [N_PORTS-1:0]           req_valid,
  input  logic [N_PORTS-1:0]           req_last,
  output logic [N_PORTS-1:0]           req_ready,
  output logic [7:0]                   tx_data,
  output logic                         tx_valid,
  input  logic                         tx_ready,
  output logic [$clog2(N_PORTS)-1:0]   owner,
  output logic                         locked,
  output logic                         timeout
);

  localparam int OW = idx_width(N_PORTS);
  localparam int CW = idx_width(MAX_IDLE);

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e          state_q, state_d;
  logic [OW-1:0]   owner_q, owner_d;
  logic [CW-1:0]   idle_cnt_q, idle_cnt_d;
  logic [OW-1:0]   grant_idx;
  logic            grant_any;
  logic [7:0]      port_data [N_PORTS];
  logic            own_valid;
  logic            own_last;

  rr_pick #(.N(N_PORTS)) u_pick (
    .req       (req_valid),
    .last_idx  (owner_q),
    .grant_idx (grant_idx),
    .any       (grant_any)
  );

  // Unpack the flat data bus and route ready only to the owning port.
  for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_port
    assign port_data[gi] = req_data[gi*8 +: 8];
    assign req_ready[gi] = (state_q == LOCKED) && (owner_q == OW'(gi)) && tx_ready;
  end

  assign own_valid = req_valid[owner_q];
  assign own_last  = req_last[owner_q];
  assign locked    = (state_q == LOCKED);
  assign owner     = owner_q;

  // State, owner pointer and stall counter; reset points owner at the last
  // port so port 0 is first in line.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      owner_q    <= OW'(N_PORTS - 1);
      idle_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      idle_cnt_q <= idle_cnt_d;
    end
  end

  // Arbitration, owner pass-through, and stall-timeout release.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    idle_cnt_d = idle_cnt_q;
    tx_data    = 8'h00;
    tx_valid   = 1'b0;
    timeout    = 1'b0;
    case (state_q)
      IDLE: begin
        idle_cnt_d = '0;
        if (grant_any) begin
          owner_d = grant_idx;
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        tx_data  = port_data[owner_q];
        tx_valid = own_valid;
        if (own_valid && tx_ready) begin
          idle_cnt_d = '0;
          if (own_last) state_d = IDLE;
        end else if (!own_valid) begin
          // UART backpressure with a byte waiting is not counted as a stall.
          if (idle_cnt_q == CW'(MAX_IDLE - 1)) begin
            timeout    = 1'b1;
            state_d    = IDLE;
            idle_cnt_d = '0;
          end else begin
            idle_cnt_d = idle_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with N_PORTS=4, MAX_IDLE=8.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] req_data;
  logic [3:0]  req_valid;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [1:0]  owner;
  logic        locked;
  logic        timeout;

  int total = 0;
  int bad   = 0;
  int rr_exp [6];

  always #5 clk = ~clk;

  uart_tx_arbiter #(.N_PORTS(4), .MAX_IDLE(8)) dut (
    .clock     (clk),
    .reset     (rst),
    .req_data  (req_data),
    .req_valid (req_valid),
    .req_last  (req_last),
    .req_ready (req_ready),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .owner     (owner),
    .locked    (locked),
    .timeout   (timeout)
  );

  // One line per accepted byte.
  always @(negedge clk) begin
    if (!rst && tx_valid && tx_ready)
      $display("xfer owner=%0d data=0x%02h last=%0b", owner, tx_data, req_last[owner]);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int p, input logic [7:0] d, input logic v, input logic l);
    req_data[8*p +: 8] = d;
    req_valid[p]       = v;
    req_last[p]        = l;
  endtask

  initial begin
    rst = 1'b1; req_data = '0; req_valid = '0; req_last = '0; tx_ready = 1'b1;
    rr_exp = '{3, 0, 1, 2, 3, 0};
    step(); step();
    rst = 1'b0; #1;
    chk("rst_locked", 32'(locked), 0);
    chk("rst_owner", 32'(owner), 3);
    chk("rst_tx_valid", 32'(tx_valid), 0);
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_tx_data", 32'(tx_data), 0);
    chk("rst_timeout", 32'(timeout), 0);

    // Ports 0 and 2 contend; port 0 wins, sends 3 bytes, then port 2.
    set_port(0, 8'h41, 1'b1, 1'b0); set_port(2, 8'h99, 1'b1, 1'b1); #1;
    chk("p1_idle_locked", 32'(locked), 0);
    chk("p1_idle_ready", 32'(req_ready), 0);
    step(); #1;
    chk("p1_owner", 32'(owner), 0);
    chk("p1_locked", 32'(locked), 1);
    chk("p1_b0", 32'(tx_data), 32'h41);
    chk("p1_valid", 32'(tx_valid), 1);
    chk("p1_ready", 32'(req_ready), 32'b0001);
    step(); set_port(0, 8'h42, 1'b1, 1'b0); #1;
    chk("p1_b1", 32'(tx_data), 32'h42);
    chk("p1_nonowner_ready", 32'(req_ready), 32'b0001);
    step(); set_port(0, 8'h43, 1'b1, 1'b1); #1;
    chk("p1_b2", 32'(tx_data), 32'h43);
    step(); set_port(0, 8'h00, 1'b0, 1'b0); #1;
    chk("p1_dead_locked", 32'(locked), 0);
    chk("p1_dead_valid", 32'(tx_valid), 0);
    chk("p1_dead_owner", 32'(owner), 0);
    step(); #1;
    chk("p2_owner", 32'(owner), 2);
    chk("p2_locked", 32'(locked), 1);
    chk("p2_data", 32'(tx_data), 32'h99);
    chk("p2_ready", 32'(req_ready), 32'b0100);

    // All ports request single-byte packets continuously.
    step();
    for (int p = 0; p < 4; p++) set_port(p, 8'hA0 + 8'(p), 1'b1, 1'b1);
    #1;
    chk("rr_idle", 32'(locked), 0);
    for (int k = 0; k < 6; k++) begin
      step(); #1;
      chk("rr_owner", 32'(owner), 32'(rr_exp[k]));
      chk("rr_data", 32'(tx_data), 32'hA0 + 32'(rr_exp[k]));
      chk("rr_ready", 32'(req_ready), 32'(1) << rr_exp[k]);
      step(); #1;
      chk("rr_dead", 32'(locked), 0);
    end
    req_valid = '0; req_last = '0; req_data = '0;

    // Port 1 sends one byte then stalls; port 3 waits behind it.
    step();
    set_port(1, 8'h10, 1'b1, 1'b0); set_port(3, 8'h33, 1'b1, 1'b1); #1;
    chk("to_idle", 32'(locked), 0);
    step(); #1;
    chk("to_owner", 32'(owner), 1);
    chk("to_data", 32'(tx_data), 32'h10);
    step(); set_port(1, 8'h00, 1'b0, 1'b0); #1;
    for (int k = 1; k <= 8; k++) begin
      if (k > 1) begin step(); #1; end
      chk("to_pulse", 32'(timeout), 32'(k == 8));
      chk("to_locked", 32'(locked), 1);
    end
    step(); #1;
    chk("to_released", 32'(locked), 0);
    chk("to_pulse_gone", 32'(timeout), 0);
    step(); #1;
    chk("to_next_owner", 32'(owner), 3);
    chk("to_next_locked", 32'(locked), 1);
    chk("to_next_data", 32'(tx_data), 32'h33);

    // Owner held off by UART backpressure well past MAX_IDLE cycles.
    step(); set_port(3, 8'h00, 1'b0, 1'b0); set_port(0, 8'h55, 1'b1, 1'b1); tx_ready = 1'b0; #1;
    chk("bp_idle", 32'(locked), 0);
    step(); #1;
    chk("bp_owner", 32'(owner), 0);
    chk("bp_valid", 32'(tx_valid), 1);
    chk("bp_ready_low", 32'(req_ready), 0);
    for (int i = 0; i < 20; i++) begin
      step(); #1;
      chk("bp_no_timeout", 32'(timeout), 0);
      chk("bp_held", 32'(locked), 1);
    end
    tx_ready = 1'b1; #1;
    chk("bp_accept", 32'(req_ready), 32'b0001);
    chk("bp_data", 32'(tx_data), 32'h55);
    step(); set_port(0, 8'h00, 1'b0, 1'b0); #1;
    chk("bp_done", 32'(locked), 0);

    // Reset while port 1 is mid-packet.
    set_port(1, 8'h77, 1'b1, 1'b0); #1;
    step(); #1;
    chk("rm_owner", 32'(owner), 1);
    chk("rm_locked", 32'(locked), 1);
    step(); set_port(1, 8'h78, 1'b1, 1'b0); rst = 1'b1; #1;
    chk("rm_still_locked", 32'(locked), 1);
    step(); rst = 1'b0; set_port(1, 8'h00, 1'b0, 1'b0); set_port(0, 8'h5A, 1'b1, 1'b1); #1;
    chk("rm_locked", 32'(locked), 0);
    chk("rm_tx_valid", 32'(tx_valid), 0);
    chk("rm_owner_reset", 32'(owner), 3);
    step(); #1;
    chk("rm_relock_owner", 32'(owner), 0);
    chk("rm_relock_data", 32'(tx_data), 32'h5A);
    step(); set_port(0, 8'h00, 1'b0, 1'b0); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
